// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. Single-cycle ops
// finish in one edge; MUL is a WIDTH-step shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] alua,
  input  logic [WIDTH-1:0] alub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alur,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t state, state_nxt;

  logic             accept;
  logic             is_mul;
  logic             last_step;
  logic [WIDTH-1:0] res;
  logic             res_c, res_o, res_e;
  logic [WIDTH:0]   sum, diff;

  logic [2*WIDTH-1:0] acc, acc_nxt, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign accept    = in_valid & in_ready;
  assign is_mul    = (aluop == OP_MUL);
  assign last_step = (cnt == CW'(WIDTH - 1));
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;

  // NOTE: flops use non-blocking assignments and reset asynchronously so every
  // output clears the moment rst rises, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational block assigns defaults first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nxt = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (last_step) state_nxt = S_DONE;
      S_DONE: if (out_ready) begin
        if (in_valid) state_nxt = is_mul ? S_MUL : S_DONE;
        else          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    out_valid = (state == S_DONE);
  end

  // Single-cycle result and flags from the live operands; only used on accept.
  always_comb begin
    sum   = {1'b0, alua} + {1'b0, alub};
    diff  = {1'b0, alua} - {1'b0, alub};
    res   = '0;
    res_c = 1'b0;
    res_o = 1'b0;
    res_e = 1'b0;
    case (aluop)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_o = (alua[WIDTH-1] == alub[WIDTH-1]) & (sum[WIDTH-1] != alua[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_o = (alua[WIDTH-1] != alub[WIDTH-1]) & (diff[WIDTH-1] != alua[WIDTH-1]);
      end
      OP_AND:  res = alua & alub;
      OP_OR:   res = alua | alub;
      OP_XOR:  res = alua ^ alub;
      OP_NOR:  res = ~(alua | alub);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(alua) < $signed(alub))};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (alua < alub)};
      OP_SLL:  res = alua << alub[SHW-1:0];
      OP_SRL:  res = alua >> alub[SHW-1:0];
      OP_SRA:  res = $signed(alua) >>> alub[SHW-1:0];
      OP_MUL:  res = '0;
      default: res_e = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alur     <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, alua};
        mplier <= alub;
        cnt    <= '0;
      end else begin
        alur     <= res;
        zero     <= (res == '0);
        carry    <= res_c;
        overflow <= res_o;
        err      <= res_e;
      end
    end else if (state == S_MUL) begin
      // One multiplier bit per edge; the final step publishes the product.
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        alur     <= acc_nxt[WIDTH-1:0];
        zero     <= (acc_nxt[WIDTH-1:0] == '0);
        carry    <= |acc_nxt[2*WIDTH-1:WIDTH];
        overflow <= 1'b0;
        err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH = 32): directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluop;
  logic [W-1:0] alua, alub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alur;
  logic         zero, carry, overflow, err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_r;
  logic         last_z, last_c, last_o, last_e;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .alua(alua), .alub(alub), .out_valid(out_valid),
    .out_ready(out_ready), .alur(alur), .zero(zero), .carry(carry),
    .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: true-width integer arithmetic, then truncated to W bits.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic e);
    longint      sa, sb, sr;
    logic [63:0] p;
    int          sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    r = '0; c = 1'b0; o = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin
        p = {32'b0, a} + {32'b0, b}; r = p[W-1:0]; c = p[W];
        sr = sa + sb; o = (sr != longint'($signed(r)));
      end
      4'd1: begin
        r = a - b; c = (a < b);
        sr = sa - sb; o = (sr != longint'($signed(r)));
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
      4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd8:  r = a << sh;
      4'd9:  r = a >> sh;
      4'd10: begin sr = sa >>> sh; r = sr[W-1:0]; end
      4'd11: begin p = {32'b0, a} * {32'b0, b}; r = p[W-1:0]; c = (p[63:32] != 0); end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE, wait for the result, check it, then consume it.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
    logic [W-1:0] er;
    logic         ec, eo, ee;
    int           lat;
    bit           busy_ok;
    model(op, a, b, er, ec, eo, ee);
    @(negedge clk);
    check({tag, ".in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1; aluop = op; alua = a; alub = b;
    @(posedge clk); #1;
    in_valid = 1'b0; aluop = 4'($urandom); alua = $urandom; alub = $urandom;
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 3 * W) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".out_valid"}, W'(out_valid), W'(1));
    check({tag, ".latency"}, W'(lat), (op == 4'd11) ? W'(W) : W'(0));
    check({tag, ".busy"}, W'(busy_ok), W'(1));
    check({tag, ".alur"}, alur, er);
    check({tag, ".zero"}, W'(zero), W'(er == '0));
    check({tag, ".carry"}, W'(carry), W'(ec));
    check({tag, ".overflow"}, W'(overflow), W'(eo));
    check({tag, ".err"}, W'(err), W'(ee));
    last_r = alur; last_z = zero; last_c = carry; last_o = overflow; last_e = err;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; alua = '0; alub = '0;
    #12;
    check("reset.out_valid", W'(out_valid), W'(0));
    check("reset.alur", alur, '0);
    check("reset.flags", W'({zero, carry, overflow, err}), W'(0));
    check("reset.in_ready", W'(in_ready), W'(1));
    @(negedge clk); rst = 1'b0;

    run_op(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, "add_wrap");
    check("add_wrap.const", W'({last_r != 0, last_z, last_c, last_o}), W'(4'b0110));
    run_op(4'd1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
    check("sub_ovf.const", last_r, 32'h7FFF_FFFF);
    check("sub_ovf.flags", W'({last_c, last_o}), W'(2'b01));
    run_op(4'd10, 32'h8000_0000, 32'h0000_0024, "sra");
    check("sra.const", last_r, 32'hF800_0000);
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, "mul_hi");
    check("mul_hi.const", W'({last_r != 0, last_z, last_c}), W'(3'b011));
    run_op(4'd11, 32'd7, 32'd6, "mul_small");
    check("mul_small.const", last_r, 32'd42);
    check("mul_small.carry", W'(last_c), W'(0));
    run_op(4'd13, $urandom, $urandom, "illegal");
    check("illegal.const", W'({last_r != 0, last_z, last_e}), W'(3'b011));
    run_op(4'd2, 32'h0000_00FF, 32'h0000_0F0F, "after_illegal");
    check("after_illegal.err", W'(last_e), W'(0));

    // Backpressure then back-to-back accept on the releasing edge.
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd0; alua = 32'd2; alub = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp.alur", alur, 32'd5);
      check("bp.hold", W'({out_valid, in_ready}), W'(2'b10));
      @(posedge clk); #1;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; aluop = 4'd2; alua = 32'h0000_F0F0; alub = 32'h0000_0FF0;
    #1 check("b2b.in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.out_valid", W'(out_valid), W'(1));
    check("b2b.alur", alur, 32'h0000_00F0);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset in the middle of a multiply.
    @(negedge clk);
    in_valid = 1'b1; aluop = 4'd11; alua = 32'd1234; alub = 32'd5678;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst.alur", alur, 32'h0000_00F0);
    rst = 1'b1;
    #1;
    check("mid_rst.out_valid", W'(out_valid), W'(0));
    check("mid_rst.alur", alur, '0);
    check("mid_rst.flags", W'({zero, carry, overflow, err}), W'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst.in_ready", W'(in_ready), W'(1));
    quiet = 1'b1;
    repeat (W + 4) begin
      if (out_valid) quiet = 1'b0;
      @(posedge clk); #1;
    end
    check("post_rst.no_result", W'(quiet), W'(1));
    run_op(4'd0, 32'd2, 32'd3, "post_rst_add");
    check("post_rst_add.const", last_r, 32'd5);

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; power of two, >= 8.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width, taken from alub[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 aluop  input  4  operation code.
REQ-008 alua  input  WIDTH  operand A.
REQ-009 alub  input  WIDTH  operand B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 alur  output  WIDTH  result.
REQ-013 zero  output  1  alur == 0.
REQ-014 carry  output  1  carry/borrow/high-product flag.
REQ-015 overflow  output  1  signed overflow flag.
REQ-016 err  output  1  illegal opcode flag.

Function
REQ-017 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT signed, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MUL; 12-15 illegal.
REQ-018 Accept = in_valid & in_ready at a rising edge; operands and aluop are captured then, later input changes ignored.
REQ-019 FSM states IDLE, MUL, DONE; in_ready = (IDLE) | (DONE & out_ready), combinational.
REQ-020 Non-MUL op accepted at edge N: alur/flags registered at edge N, out_valid high from edge N to handshake (latency 1 cycle).
REQ-021 MUL accepted at edge N: state MUL, shift-add one multiplier bit per edge, WIDTH edges; result registered and out_valid high after edge N+WIDTH; in_ready low throughout.
REQ-022 MUL result = low WIDTH bits of unsigned product; carry = 1 iff upper WIDTH bits nonzero; overflow = 0.
REQ-023 ADD: carry = unsigned carry-out; overflow = signed overflow; all arithmetic modulo 2^WIDTH.
REQ-024 SUB: carry = borrow (alua < alub unsigned); overflow = signed overflow.
REQ-025 SLT/SLTU: alur = {WIDTH-1 zeros, compare bit}; shifts use alub[SHW-1:0] only; SRA sign-fills.
REQ-026 Logic, compare and shift ops: carry = 0, overflow = 0.
REQ-027 Illegal op: alur = 0, zero = 1, carry = overflow = 0, err = 1, latency 1; err = 0 for legal ops.
REQ-028 DONE: alur and all flags held stable while out_valid & ~out_ready; out_valid drops after handshake unless new request accepted same edge.
REQ-029 DONE & out_ready & in_valid: result consumed and new request accepted on same edge (back-to-back, no bubble for 1-cycle ops).
REQ-030 DONE & out_ready & ~in_valid: return to IDLE, out_valid = 0 next cycle.

Reset
REQ-031 rst high: state IDLE, out_valid = 0, alur = 0, zero = 0, carry = 0, overflow = 0, err = 0, MUL counter/accumulator cleared, immediately and asynchronously.
REQ-032 rst mid-MUL or in DONE: operation abandoned, no result delivered; in_ready = 1 in first cycle after rst deasserts.

Verification (WIDTH = 32)
REQ-033 ADD 0xFFFF_FFFF + 0x0000_0001 -> alur 0x0000_0000, zero 1, carry 1, overflow 0, out_valid one cycle after accept.
REQ-034 SUB 0x8000_0000 - 0x0000_0001 -> alur 0x7FFF_FFFF, overflow 1, carry 0; SRA 0x8000_0000 by alub 0x24 -> alur 0xF800_0000.
REQ-035 MUL 0x0001_0000 * 0x0001_0000 -> alur 0, zero 1, carry 1, out_valid exactly 32 edges after accept, in_ready 0 throughout; MUL 7*6 -> 42, carry 0.
REQ-036 Backpressure: out_ready low 5 cycles after ADD 2+3 -> alur 5 held, in_ready 0; then out_ready = 1 with in_valid = 1 (AND 0xF0F0 & 0x0FF0) -> accepted same edge, alur 0x00F0 next cycle.
REQ-037 rst pulse during MUL iteration 10 -> all outputs 0 at once, in_ready 1 after release, following ADD 2+3 -> 5.
REQ-038 aluop 13 with any operands -> alur 0, zero 1, err 1; next legal op clears err.
